// File: rtl/sdm_sample_scheduler.sv
// sdm_sample_scheduler: FIFO-buffered sample feed for a sigma-delta modulator, one word per OSR clocks,
// holding the last word on underrun and fading linearly to silence when playback stops or starves.
module sdm_sample_scheduler #(
    parameter int N         = 16,
    parameter int OSR       = 64,
    parameter int DEPTH     = 4,
    parameter int HOLD_LIM  = 8,
    parameter int FADE_STEP = 256
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         enable,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic [N-1:0] din_out,
    output logic         sample_tick,
    output logic         underrun,
    output logic [1:0]   state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OSR);
    localparam int HW = $clog2(HOLD_LIM + 1);
    localparam logic [N:0] STEP = (N+1)'(FADE_STEP);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, FADE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] tick_q;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic [N-1:0]  din_q, din_d, faded;
    logic [N:0]    din_x, mag;
    logic          tick, empty, flush, push, pop;

    assign tick        = tick_q == CW'(OSR - 1);
    assign empty       = cnt_q == '0;
    assign flush       = state_q == IDLE && !enable;
    assign s_ready     = !areset && cnt_q != (AW+1)'(DEPTH) && !flush;
    assign push        = s_valid && s_ready;
    assign cnt_d       = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign hold_inc    = hold_q + HW'(1);
    // One extra sign bit so the most negative word has a representable magnitude.
    assign din_x       = {din_q[N-1], din_q};
    assign mag         = din_q[N-1] ? -din_x : din_x;
    assign faded       = mag <= STEP ? '0 : N'(din_q[N-1] ? din_x + STEP : din_x - STEP);
    assign sample_tick = tick;
    assign state       = state_q;
    assign din_out     = din_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        din_d    = din_q;
        pop      = 1'b0;
        underrun = 1'b0;
        case (state_q)
            IDLE: begin
                din_d = '0;
                if (tick && enable && cnt_q >= (AW+1)'(2)) begin
                    state_d = RUN;
                    pop     = 1'b1;
                end
            end
            RUN, HOLD: begin
                if (!enable) state_d = FADE;
                else if (tick && !empty) begin
                    state_d = RUN;
                    pop     = 1'b1;
                end else if (tick) begin
                    underrun = 1'b1;
                    hold_d   = hold_inc;
                    state_d  = hold_inc >= HW'(HOLD_LIM) ? FADE : HOLD;
                end
            end
            FADE: begin
                if (din_q == '0) state_d = IDLE;
                else if (tick) din_d = faded;
            end
        endcase
        if (pop) din_d = mem_q[rd_q];
        if (state_d != HOLD) hold_d = '0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            tick_q  <= '0;
            hold_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= flush ? '0 : rd_q + AW'(pop);
            wr_q    <= flush ? '0 : wr_q + AW'(push);
            tick_q  <= tick ? '0 : tick_q + CW'(1);
            hold_q  <= hold_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= s_data;
    end
endmodule

// File: tb/tb_sdm_sample_scheduler.sv
// tb_sdm_sample_scheduler: directed literal scenarios plus a randomized run scored every cycle
// against a queue-based behavioural model of the scheduler.
module tb_sdm_sample_scheduler;
    localparam int N = 16, OSR = 4, DEPTH = 4, HOLD_LIM = 2, FSTEP = 32'h4000;

    logic         clk = 1'b0;
    logic         areset, enable, s_valid, s_ready, sample_tick, underrun;
    logic [N-1:0] s_data, din_out;
    logic [1:0]   state;
    logic         ur;
    int           n_cmp = 0, n_bad = 0, vprob = 50;
    bit           chk_on = 1'b0;

    // Model: FIFO as a queue, tick phase, mode 0..3, consecutive empty ticks, output word as signed int.
    int q[$];
    int mt, mm, mh, md;
    bit mtk, mrdy, mpu, mpo;

    sdm_sample_scheduler #(.N(N), .OSR(OSR), .DEPTH(DEPTH), .HOLD_LIM(HOLD_LIM), .FADE_STEP(FSTEP)) dut (
        .clk(clk), .areset(areset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .din_out(din_out), .sample_tick(sample_tick), .underrun(underrun), .state(state)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            q.delete();
            mt = 0; mm = 0; mh = 0; md = 0;
        end else begin
            mtk  = mt == OSR - 1;
            mrdy = q.size() < DEPTH && !(mm == 0 && !enable);
            mpu  = s_valid && mrdy;
            mpo  = 1'b0;
            case (mm)
                0: if (!enable) q.delete();
                   else if (mtk && q.size() >= 2) begin mpo = 1'b1; mm = 1; end
                1, 2: if (!enable) mm = 3;
                   else if (mtk && q.size() > 0) begin mpo = 1'b1; mm = 1; end
                   else if (mtk) begin mh++; mm = (mh >= HOLD_LIM) ? 3 : 2; end
                default: if (md == 0) mm = 0;
                   else if (mtk) md = (md <= FSTEP && md >= -FSTEP) ? 0 : (md > 0 ? md - FSTEP : md + FSTEP);
            endcase
            if (mpo) md = q.pop_front();
            if (mpu) q.push_back(int'($signed(s_data)));
            if (mm != 2) mh = 0;
            mt = (mt + 1) % OSR;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_ready", s_ready, !areset && q.size() < DEPTH && !(mm == 0 && !enable));
            chk("m_tick", sample_tick, !areset && mt == OSR - 1);
            chk("m_underrun", underrun, !areset && mt == OSR - 1 && (mm == 1 || mm == 2) && enable && q.size() == 0);
            chk("m_state", state, mm);
            chk("m_din", din_out, md & 32'hFFFF);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [N-1:0] v);
        s_valid = 1'b1; s_data = v;
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_tick_neg(output logic u);
        int n;
        n = 0;
        @(negedge clk);
        while (sample_tick !== 1'b1 && n < 2 * OSR) begin @(negedge clk); n++; end
        chk("tick_seen", sample_tick, 1);
        u = underrun;
    endtask

    task automatic to_tick(output logic u);
        wait_tick_neg(u);
        step();
    endtask

    initial begin
        areset = 1'b0; enable = 1'b1; s_valid = 1'b0; s_data = '0;
        #1 areset = 1'b1;
        #1 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din", din_out, 0); chk("rst_state", state, 0); chk("rst_ready", s_ready, 0);
        chk("rst_tick", sample_tick, 0); chk("rst_underrun", underrun, 0);
        areset = 1'b0;
        push(16'h1000); push(16'h2000); push(16'h3000);
        to_tick(ur); chk("run_state", state, 1); chk("run_din0", din_out, 16'h1000);
        to_tick(ur); chk("run_din1", din_out, 16'h2000);
        to_tick(ur); chk("run_din2", din_out, 16'h3000);
        to_tick(ur); chk("ur1_pulse", ur, 1); chk("ur1_state", state, 2); chk("ur1_din", din_out, 16'h3000);
        to_tick(ur); chk("ur2_pulse", ur, 1); chk("ur2_state", state, 3);
        to_tick(ur); chk("fade_din", din_out, 0); chk("fade_state", state, 3);
        step(); chk("fade_idle", state, 0);
        push(16'h8000); push(16'h7000);
        to_tick(ur); chk("neg_din", din_out, 16'h8000);
        enable = 1'b0;
        step(); chk("dis_state", state, 3); chk("dis_din", din_out, 16'h8000);
        to_tick(ur); chk("negfade1", din_out, 16'hC000);
        to_tick(ur); chk("negfade2", din_out, 0);
        step(); chk("negfade_idle", state, 0);
        step();
        enable = 1'b1;
        wait_tick_neg(ur);
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_data = 16'(16'h0100 * (k + 1));
            chk("fill_ready", s_ready, k < 4);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("fill_reready", s_ready, 1); chk("fill_state", state, 1); chk("fill_din", din_out, 16'h0100);
        to_tick(ur); chk("drain1", din_out, 16'h0200);
        to_tick(ur); chk("drain2", din_out, 16'h0300);
        to_tick(ur); chk("drain3", din_out, 16'h0400);
        wait_tick_neg(ur);
        s_valid = 1'b1; s_data = 16'h5555;
        chk("tickpush_ur", ur, 1);
        step();
        s_valid = 1'b0;
        chk("tickpush_hold", state, 2); chk("tickpush_din", din_out, 16'h0400);
        to_tick(ur); chk("tickpush_nour", ur, 0); chk("tickpush_run", state, 1); chk("tickpush_pop", din_out, 16'h5555);
        enable = 1'b0;
        step(); chk("rstfade_state", state, 3);
        enable = 1'b1;
        #2 areset = 1'b1;
        #1 chk("arst_din", din_out, 0); chk("arst_state", state, 0); chk("arst_ready", s_ready, 0);
        @(posedge clk); #1;
        areset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0)
                case ($urandom_range(0, 3))
                    0: vprob = 5;
                    1: vprob = 25;
                    2: vprob = 60;
                    default: vprob = 100;
                endcase
            areset = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 49) == 0) enable = !enable;
            s_valid = $urandom_range(0, 99) < vprob;
            case ($urandom_range(0, 7))
                0: s_data = 16'h8000;
                1: s_data = 16'h7FFF;
                2, 3: s_data = 16'($urandom_range(0, 32'h5000));
                default: s_data = 16'($urandom);
            endcase
            step();
        end
        areset = 1'b0; s_valid = 1'b0;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
